perf_counter_bank: RTL and testbench

Synthesizable, parametrised performance-counter bank for the pipelined processor hierarchy. It counts per-channel events such as instruction retire, I/D-cache request and I/D-cache hit, plus a free-running cycle count. All counting freezes on halt, so the final values stay stable for readout. Software-visible registers, on-chip debug and the simulation bench all read the counters through a one-cycle registered read port.

---
 rtl/perf_pkg.sv | 16 +
 rtl/perf_cnt.sv | 59 +++++
 rtl/perf_counter_bank.sv | 116 +++++++++++
 tb/tb_perf_counter_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter bank: state encoding and
// the fixed meaning of the low event channels.
package perf_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      FROZEN = 1'b1
   } perf_state_e;

   // Event channel assignment; further channels (DHIT, ...) follow CH_DREQ.
   localparam int CH_INST = 0;
   localparam int CH_IREQ = 1;
   localparam int CH_IHIT = 2;
   localparam int CH_DREQ = 3;

endpackage

// File: rtl/perf_cnt.sv
// Single unsigned counter with sticky overflow flag.
// Define PERF_SATURATE_EN to saturate at all-ones instead of wrapping.
module perf_cnt
   import perf_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             hold_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             at_max;

   assign at_max = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i && !hold_i) begin
`ifdef PERF_SATURATE_EN
         // A blocked increment at all-ones is what flags the overflow.
         if (at_max) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
`else
         cnt_d = cnt_q + CNT_W'(1);
         if (at_max) begin
            ovf_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank plus free-running cycle counter with a registered read port.
// Counter overflow behaviour is selected by PERF_SATURATE_EN (see perf_cnt).
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int SEL_W  = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [NUM_CH-1:0] evt,
   input  logic              halt,
   input  logic              rd_req,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic              rd_ack,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_err,
   output logic [NUM_CH:0]   ovf,
   output logic              frozen
);

   localparam logic [SEL_W-1:0] CYC_SEL = SEL_W'(NUM_CH);

   perf_state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_w [NUM_CH+1];
   logic [NUM_CH:0]  inc_w;
   logic             hold_w;

   logic [CNT_W-1:0] rd_mux;
   logic             rd_bad;
   logic             rd_ack_q, rd_ack_d;
   logic             rd_err_q, rd_err_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN:     if (halt) state_d = FROZEN;
            FROZEN:  state_d = FROZEN;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign frozen = (state_q == FROZEN);

   // The halt cycle still counts: hold depends only on the registered state.
   assign hold_w = frozen || !en;
   assign inc_w  = {1'b1, evt};

   for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
      perf_cnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i  (clk),
         .rst_i  (rst),
         .clr_i  (clr),
         .inc_i  (inc_w[g]),
         .hold_i (hold_w),
         .cnt_o  (cnt_w[g]),
         .ovf_o  (ovf[g])
      );
   end

   assign rd_bad = (rd_sel > CYC_SEL);

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i <= NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_mux = cnt_w[i];
         end
      end
   end

   always_comb begin
      rd_ack_d  = rd_req;
      rd_err_d  = rd_req && rd_bad;
      rd_data_d = rd_data_q;
      if (rd_req) begin
         rd_data_d = rd_bad ? '0 : rd_mux;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ack_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_ack_q  <= rd_ack_d;
         rd_err_q  <= rd_err_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_ack  = rd_ack_q;
   assign rd_err  = rd_err_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wide (32-bit) and a narrow (4-bit) instance
// driven in lockstep and compared against an unbounded-count reference model.
module tb_perf_counter_bank;

   localparam int NCH = 4;
   localparam int SW  = $clog2(NCH + 1);

   logic clk = 1'b0;
   logic rst;
   logic en, clr, halt, rd_req;
   logic [NCH-1:0] evt;
   logic [SW-1:0]  rd_sel;

   logic           ack_w, err_w, frz_w;
   logic [31:0]    data_w;
   logic [NCH:0]   ovf_w;
   logic           ack_n, err_n, frz_n;
   logic [3:0]     data_n;
   logic [NCH:0]   ovf_n;

   int total = 0;
   int bad   = 0;

   longint unsigned tc [NCH+1];
   bit              m_frz;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_CH(NCH), .CNT_W(32)) u_w (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(ack_w), .rd_data(data_w),
      .rd_err(err_w), .ovf(ovf_w), .frozen(frz_w));

   perf_counter_bank #(.NUM_CH(NCH), .CNT_W(4)) u_n (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(ack_n), .rd_data(data_n),
      .rd_err(err_n), .ovf(ovf_n), .frozen(frz_n));

   function automatic longint unsigned lim(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Value a w-bit counter shows after t true increments.
   function automatic longint unsigned view(input longint unsigned t, input int w);
`ifdef PERF_SATURATE_EN
      return (t > lim(w)) ? lim(w) : t;
`else
      return t & lim(w);
`endif
   endfunction

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i <= NCH; i++) tc[i] = 0;
      m_frz = 1'b0;
   endtask

   task automatic idle();
      en = 0; clr = 0; halt = 0; evt = '0; rd_req = 0; rd_sel = '0;
   endtask

   // One clock: predict from the model with the current inputs, then compare.
   task automatic step();
      bit              x_ack, x_err;
      longint unsigned x_w, x_n;
      logic [NCH:0]    x_ow, x_on;
      int              s;
      s     = int'(rd_sel);
      x_ack = rd_req;
      x_err = rd_req && (s > NCH);
      x_w   = 0;
      x_n   = 0;
      if (rd_req && !x_err) begin
         x_w = view(tc[s], 32);
         x_n = view(tc[s], 4);
      end
      if (clr) begin
         model_reset();
      end else if (!m_frz) begin
         if (en) begin
            tc[NCH]++;
            for (int i = 0; i < NCH; i++) if (evt[i]) tc[i]++;
         end
         if (halt) m_frz = 1'b1;
      end
      for (int i = 0; i <= NCH; i++) begin
         x_ow[i] = (tc[i] > lim(32));
         x_on[i] = (tc[i] > lim(4));
      end
      @(posedge clk);
      #1;
      chk("ack_w", ack_w, x_ack);
      chk("ack_n", ack_n, x_ack);
      if (x_ack) begin
         chk("data_w", data_w, x_w);
         chk("data_n", data_n, x_n);
         chk("err_w", err_w, x_err);
         chk("err_n", err_n, x_err);
      end
      chk("frozen_w", frz_w, m_frz);
      chk("frozen_n", frz_n, m_frz);
      chk("ovf_w", ovf_w, x_ow);
      chk("ovf_n", ovf_n, x_on);
   endtask

   task automatic apply_reset();
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit              en;
      bit              halt;
      logic [NCH-1:0]  evt;
      bit              req;
      logic [SW-1:0]   sel;
      bit              x_ack;
      longint unsigned x_data;
      bit              x_err;
      bit              x_frz;
   } vec_t;

   vec_t tbl[$];

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", ack_w, 0);
      chk("rst_data", data_w, 0);
      chk("rst_err", err_w, 0);
      chk("rst_ovf", ovf_w, 0);
      chk("rst_frozen", frz_w, 0);
      rst = 1'b0;

      // Ten cycles of evt=0101, then reads of every select plus an illegal one.
      for (int i = 0; i < 10; i++) tbl.push_back('{1, 0, 4'b0101, 0, 3'd0, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 4'b0000, 1, 3'd0, 1, 10, 0, 0});
      tbl.push_back('{1, 0, 4'b0000, 1, 3'd1, 1, 0,  0, 0});
      tbl.push_back('{1, 0, 4'b0000, 1, 3'd2, 1, 10, 0, 0});
      tbl.push_back('{1, 0, 4'b0000, 1, 3'd3, 1, 0,  0, 0});
      tbl.push_back('{1, 0, 4'b0000, 1, 3'd4, 1, 14, 0, 0});
      tbl.push_back('{1, 0, 4'b0000, 1, 3'd5, 1, 0,  1, 0});
      tbl.push_back('{0, 0, 4'b0000, 0, 3'd0, 0, 0,  0, 0});
      foreach (tbl[k]) begin
         idle();
         en = tbl[k].en; halt = tbl[k].halt; evt = tbl[k].evt;
         rd_req = tbl[k].req; rd_sel = tbl[k].sel;
         step();
         chk("tbl_ack", ack_w, tbl[k].x_ack);
         if (tbl[k].x_ack) begin
            chk("tbl_data", data_w, tbl[k].x_data);
            chk("tbl_err", err_w, tbl[k].x_err);
         end
         chk("tbl_frozen", frz_w, tbl[k].x_frz);
      end

      // Halt: the halt-cycle event counts, later ones do not.
      apply_reset();
      for (int i = 0; i < 3; i++) begin idle(); en = 1; evt = 4'b0001; step(); end
      idle(); en = 1; evt = 4'b0001; halt = 1; step();
      chk("halt_frozen", frz_w, 1);
      for (int i = 0; i < 5; i++) begin idle(); en = 1; evt = 4'b0001; step(); end
      idle(); en = 1; rd_req = 1; rd_sel = 0; step();
      chk("halt_ch0", data_w, 4);
      idle(); en = 1; rd_req = 1; rd_sel = 4; step();
      chk("halt_cyc", data_w, 4);
      idle(); en = 1; evt = 4'b0001; halt = 1; clr = 1; step();
      chk("clr_frozen", frz_w, 0);
      idle(); rd_req = 1; rd_sel = 0; step();
      chk("clr_ch0", data_w, 0);
      idle(); rd_req = 1; rd_sel = 4; step();
      chk("clr_cyc", data_w, 0);

      // Read in the same cycle as an increment returns the old value.
      apply_reset();
      for (int i = 0; i < 2; i++) begin idle(); en = 1; evt = 4'b0001; step(); end
      idle(); en = 1; evt = 4'b0001; rd_req = 1; rd_sel = 0; step();
      chk("coincide_old", data_w, 2);
      idle(); rd_req = 1; rd_sel = 0; step();
      chk("coincide_new", data_w, 3);

      // 17 strobes into a 4-bit counter.
      apply_reset();
      for (int i = 0; i < 17; i++) begin idle(); en = 1; evt = 4'b0010; step(); end
      idle(); rd_req = 1; rd_sel = 1; step();
`ifdef PERF_SATURATE_EN
      chk("narrow_ch1", data_n, 15);
`else
      chk("narrow_ch1", data_n, 1);
`endif
      chk("narrow_ovf1", ovf_n[1], 1);
      chk("narrow_ovf0", ovf_n[0], 0);
      chk("narrow_ovfcyc", ovf_n[NCH], 1);
      chk("wide_ovf1", ovf_w[1], 0);
      chk("wide_ch1", data_w, 17);

      // Asynchronous reset while frozen, counting and with a read in flight.
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         idle(); en = 1; evt = 4'b1111; halt = (i == 2); step();
      end
      idle(); en = 1; evt = 4'b1111; rd_req = 1; rd_sel = 0; step();
      chk("pre_rst_ack", ack_w, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_ack", ack_w, 0);
      chk("async_data", data_w, 0);
      chk("async_err", err_w, 0);
      chk("async_ovf_n", ovf_n, 0);
      chk("async_frozen", frz_w, 0);
      @(posedge clk);
      #1;
      chk("rst_hold_ack", ack_w, 0);
      rst = 1'b0;
      idle();
      model_reset();
      step();
      chk("post_rst_ack", ack_w, 0);
      idle(); rd_req = 1; rd_sel = 0; step();
      chk("post_rst_ch0", data_w, 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         en     = ($urandom % 8) != 0;
         clr    = ($urandom % 32) == 0;
         halt   = ($urandom % 40) == 0;
         evt    = NCH'($urandom);
         rd_req = $urandom % 2;
         rd_sel = SW'($urandom_range(0, 7));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
